// File: rtl/multiport_register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiport_register_file_pkg
// Purpose  : Shared definitions for the multiport register file: FSM state
//            encoding, default-width address/data types and the zero word.
// Config   : none (REGFILE_BYPASS_EN only affects multiport_register_file)
// Revision : 1.0 - initial release
// ============================================================================
package multiport_register_file_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_DEPTH      = 32;
    localparam int c_DEFAULT_ADDR_WIDTH = $clog2(c_DEFAULT_DEPTH);

    // CLEAR zeroes the array one entry per cycle; RUN is normal operation.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef logic [c_DEFAULT_ADDR_WIDTH-1:0] addr_t;
    typedef logic [c_DEFAULT_DATA_WIDTH-1:0] data_t;

    localparam data_t c_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/multiport_register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : multiport_register_file_if
// Purpose  : Bundles the read, write, issue and ready signals of the
//            multiport register file.
// Ports    : master - decode/writeback side (drives addresses, strobes, data)
//            slave  - register file side (drives read data, pending, ready)
// Revision : 1.0 - initial release
// ============================================================================
interface multiport_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  read_addr;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  read_data;
    logic [NUM_READ-1:0]                  read_pending;
    logic [NUM_WRITE-1:0]                 write_en;
    logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] write_addr;
    logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] write_data;
    logic                                 issue_en;
    logic [ADDR_WIDTH-1:0]                issue_addr;
    logic                                 ready;

    modport master (
        output read_addr,
        input  read_data,
        input  read_pending,
        output write_en,
        output write_addr,
        output write_data,
        output issue_en,
        output issue_addr,
        input  ready
    );

    modport slave (
        input  read_addr,
        output read_data,
        output read_pending,
        input  write_en,
        input  write_addr,
        input  write_data,
        input  issue_en,
        input  issue_addr,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/multiport_register_file_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bypass_mux
// Purpose  : Per-read-port forwarding. Picks the write data of the highest
//            indexed enabled write port whose address matches the read
//            address (address 0 never forwards), else the stored array data.
//            Pending is masked when a forwarding write exists and no issue
//            to the same register happens in the same cycle.
// Ports    : i_readAddr, i_arrayData, i_arrayPending - stored view
//            i_writeEn/i_writeAddr/i_writeData        - write ports
//            i_issueEn/i_issueAddr                    - issue port
//            o_readData, o_readPending                - forwarded view
// Revision : 1.0 - initial release
// ============================================================================
module regfile_bypass_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WRITE  = 2
) (
    input  wire logic [ADDR_WIDTH-1:0]                i_readAddr,
    input  wire logic [DATA_WIDTH-1:0]                i_arrayData,
    input  wire logic                                 i_arrayPending,
    input  wire logic [NUM_WRITE-1:0]                 i_writeEn,
    input  wire logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] i_writeAddr,
    input  wire logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] i_writeData,
    input  wire logic                                 i_issueEn,
    input  wire logic [ADDR_WIDTH-1:0]                i_issueAddr,
    output logic      [DATA_WIDTH-1:0]                o_readData,
    output logic                                      o_readPending
);

    logic w_hit;
    logic w_issueHit;

    // Ascending scan: a later (higher index) match overrides earlier ones.
    always_comb begin
        w_hit      = 1'b0;
        o_readData = i_arrayData;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (i_writeEn[w] && (i_writeAddr[w] == i_readAddr) && (i_readAddr != '0)) begin
                w_hit      = 1'b1;
                o_readData = i_writeData[w];
            end
        end
        w_issueHit    = i_issueEn && (i_issueAddr == i_readAddr);
        o_readPending = (w_hit && !w_issueHit) ? 1'b0 : i_arrayPending;
    end

endmodule
`default_nettype wire

// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module   : multiport_register_file
// Purpose  : Parametrised GPR file with NUM_READ combinational read ports,
//            NUM_WRITE write ports (highest index wins on conflict), a
//            per-register pending scoreboard and a sequential clear engine
//            that zeroes one entry per cycle after reset.
// Ports    : clock - rising-edge clock
//            reset - synchronous, active-high reset
//            bus   - multiport_register_file_if.slave (reads, writes, issue,
//                    ready)
// Config   : REGFILE_BYPASS_EN - forward same-cycle write data/pending to
//            the read ports through regfile_bypass_mux
// Revision : 1.0 - initial release
// ============================================================================
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    multiport_register_file_if.slave   bus
);

    localparam int                    ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] c_DATA_ZERO = DATA_WIDTH'(c_ZERO);

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [ADDR_WIDTH-1:0]   r_clearIdx;
    logic                    w_clearing;
    logic                    w_ready;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]        r_pending;

    logic [DATA_WIDTH-1:0]   w_portData [NUM_READ];
    logic                    w_portPend [NUM_READ];

    // ------------------------------------------------------------------
    // Clear FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= CLEAR;
            r_clearIdx <= '0;
        end else begin
            r_state <= w_stateNext;
            // Wraps back to 0 on entering RUN since DEPTH is a power of two.
            if (w_clearing) begin
                r_clearIdx <= r_clearIdx + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_clearing  = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clearing = 1'b1;
                if (r_clearIdx == c_LAST_IDX) begin
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                w_ready = 1'b1;
            end
            default: begin
                w_stateNext = CLEAR;
            end
        endcase
    end

    assign bus.ready = w_ready;

    // ------------------------------------------------------------------
    // Storage array. Writes are only accepted in RUN; register 0 is never
    // written so it stays at the value the clear engine left there.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_clearing) begin
            r_mem[r_clearIdx] <= c_DATA_ZERO;
        end else if (w_ready && !reset) begin
            // Ascending order: the highest-index port's assignment lands last.
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (bus.write_en[w] && (bus.write_addr[w] != '0)) begin
                    r_mem[bus.write_addr[w]] <= bus.write_data[w];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending scoreboard. The issue update follows the write clears so a
    // same-cycle issue to the written register leaves it pending.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_clearing) begin
            r_pending[r_clearIdx] <= 1'b0;
        end else if (w_ready) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (bus.write_en[w] && (bus.write_addr[w] != '0)) begin
                    r_pending[bus.write_addr[w]] <= 1'b0;
                end
            end
            if (bus.issue_en && (bus.issue_addr != '0)) begin
                r_pending[bus.issue_addr] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (genvar r = 0; r < NUM_READ; r++) begin : g_read
            logic [DATA_WIDTH-1:0] w_arrayData;
            logic                  w_arrayPend;

            assign w_arrayData = (bus.read_addr[r] == '0) ? c_DATA_ZERO
                                                          : r_mem[bus.read_addr[r]];
            assign w_arrayPend = r_pending[bus.read_addr[r]];

`ifdef REGFILE_BYPASS_EN
            if (1) begin : g_bypass
                regfile_bypass_mux #(
                    .DATA_WIDTH (DATA_WIDTH),
                    .ADDR_WIDTH (ADDR_WIDTH),
                    .NUM_WRITE  (NUM_WRITE)
                ) u_bypass (
                    .i_readAddr     (bus.read_addr[r]),
                    .i_arrayData    (w_arrayData),
                    .i_arrayPending (w_arrayPend),
                    .i_writeEn      (bus.write_en),
                    .i_writeAddr    (bus.write_addr),
                    .i_writeData    (bus.write_data),
                    .i_issueEn      (bus.issue_en),
                    .i_issueAddr    (bus.issue_addr),
                    .o_readData     (w_portData[r]),
                    .o_readPending  (w_portPend[r])
                );
            end
`else
            if (1) begin : g_direct
                assign w_portData[r] = w_arrayData;
                assign w_portPend[r] = w_arrayPend;
            end
`endif
        end
    endgenerate

    // Outputs are held at zero until the clear engine has finished.
    always_comb begin
        bus.read_data    = '0;
        bus.read_pending = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if (w_ready) begin
                bus.read_data[r]    = w_portData[r];
                bus.read_pending[r] = w_portPend[r];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiport_register_file
// Purpose  : Directed self-checking bench for multiport_register_file with
//            default parameters. Expectations honour REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiport_register_file;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    multiport_register_file_if #(
        .DATA_WIDTH (32), .DEPTH (32), .NUM_READ (2), .NUM_WRITE (2)
    ) bus ();

    multiport_register_file #(
        .DATA_WIDTH (32), .DEPTH (32), .NUM_READ (2), .NUM_WRITE (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_en   = '0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        total++;
        if (bus.ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready actual=%0b expected=0", bus.ready);
        end
        total++;
        if (bus.read_data[0] !== 32'h0 || bus.read_pending !== 2'b00) begin
            bad++; $display("FAIL reset_read actual=%h/%b expected=0/00", bus.read_data[0], bus.read_pending);
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            total++;
            if (bus.ready !== (k == 32)) begin
                bad++; $display("FAIL clear_latency cycle=%0d actual=%0b expected=%0b", k, bus.ready, (k == 32));
            end
        end
        for (int a = 0; a < 32; a++) begin
            bus.read_addr[0] = 5'(a);
            bus.read_addr[1] = 5'(31 - a);
            #1;
            total++;
            if (bus.read_data[0] !== 32'h0 || bus.read_data[1] !== 32'h0 || bus.read_pending !== 2'b00) begin
                bad++; $display("FAIL cleared_entry addr=%0d actual=%h/%h/%b expected=0/0/00",
                                a, bus.read_data[0], bus.read_data[1], bus.read_pending);
            end
            tick();
        end
    endtask

    task automatic test_write_conflict();
        bus.write_en   = 2'b11;
        bus.write_addr = {5'd5, 5'd5};
        bus.write_data = {32'h22222222, 32'h11111111};
        tick();
        idle_inputs();
        bus.read_addr = {5'd5, 5'd5};
        #1;
        total++;
        if (bus.read_data[0] !== 32'h22222222 || bus.read_data[1] !== 32'h22222222) begin
            bad++; $display("FAIL write_conflict actual=%h/%h expected=22222222", bus.read_data[0], bus.read_data[1]);
        end
    endtask

    task automatic test_reg_zero();
        bus.write_en   = 2'b01;
        bus.write_addr = {5'd0, 5'd0};
        bus.write_data = {32'h0, 32'hDEADBEEF};
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd0;
        bus.read_addr  = {5'd0, 5'd0};
        #1;
        total++;
        if (bus.read_data[0] !== 32'h0 || bus.read_pending[0] !== 1'b0) begin
            bad++; $display("FAIL reg_zero_same_cycle actual=%h/%b expected=0/0", bus.read_data[0], bus.read_pending[0]);
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (bus.read_data[0] !== 32'h0 || bus.read_pending[0] !== 1'b0) begin
            bad++; $display("FAIL reg_zero actual=%h/%b expected=0/0", bus.read_data[0], bus.read_pending[0]);
        end
    endtask

    task automatic test_scoreboard();
        bus.read_addr  = {5'd7, 5'd7};
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        tick();
        idle_inputs();
        total++;
        if (bus.read_pending !== 2'b11) begin
            bad++; $display("FAIL issue_sets_pending actual=%b expected=11", bus.read_pending);
        end
        tick();
        tick();
        bus.write_en   = 2'b01;
        bus.write_addr = {5'd0, 5'd7};
        bus.write_data = {32'h0, 32'hABCD0001};
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd7;
        tick();
        idle_inputs();
        total++;
        if (bus.read_data[0] !== 32'hABCD0001 || bus.read_pending[0] !== 1'b1) begin
            bad++; $display("FAIL issue_write_collision actual=%h/%b expected=abcd0001/1", bus.read_data[0], bus.read_pending[0]);
        end
        bus.write_en   = 2'b10;
        bus.write_addr = {5'd7, 5'd0};
        bus.write_data = {32'h5A5A5A5A, 32'h0};
        tick();
        idle_inputs();
        total++;
        if (bus.read_data[1] !== 32'h5A5A5A5A || bus.read_pending[1] !== 1'b0) begin
            bad++; $display("FAIL write_clears_pending actual=%h/%b expected=5a5a5a5a/0", bus.read_data[1], bus.read_pending[1]);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        logic        exp_pend;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h12345678;
        exp_pend = 1'b0;
`else
        exp_same = 32'h0;
        exp_pend = 1'b1;
`endif
        bus.read_addr  = {5'd9, 5'd3};
        bus.write_en   = 2'b01;
        bus.write_addr = {5'd0, 5'd3};
        bus.write_data = {32'h0, 32'h12345678};
        #1;
        total++;
        if (bus.read_data[0] !== exp_same) begin
            bad++; $display("FAIL bypass_same_cycle actual=%h expected=%h", bus.read_data[0], exp_same);
        end
        tick();
        idle_inputs();
        total++;
        if (bus.read_data[0] !== 32'h12345678) begin
            bad++; $display("FAIL bypass_next_cycle actual=%h expected=12345678", bus.read_data[0]);
        end
        // Pending bypass on r9: issue first, then write it while reading.
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd9;
        tick();
        idle_inputs();
        total++;
        if (bus.read_pending[1] !== 1'b1) begin
            bad++; $display("FAIL r9_pending actual=%b expected=1", bus.read_pending[1]);
        end
        bus.write_en   = 2'b10;
        bus.write_addr = {5'd9, 5'd0};
        bus.write_data = {32'h00000099, 32'h0};
        #1;
        total++;
        if (bus.read_pending[1] !== exp_pend) begin
            bad++; $display("FAIL bypass_pending actual=%b expected=%b", bus.read_pending[1], exp_pend);
        end
        tick();
        idle_inputs();
        total++;
        if (bus.read_data[1] !== 32'h00000099 || bus.read_pending[1] !== 1'b0) begin
            bad++; $display("FAIL r9_after_write actual=%h/%b expected=00000099/0", bus.read_data[1], bus.read_pending[1]);
        end
    endtask

    task automatic test_mid_clear();
        reset = 1'b1;
        tick();
        total++;
        if (bus.ready !== 1'b0) begin
            bad++; $display("FAIL run_reset_ready actual=%0b expected=0", bus.ready);
        end
        reset = 1'b0;
        bus.write_en   = 2'b11;
        bus.write_addr = {5'd5, 5'd4};
        bus.write_data = {32'hFFFFFFFF, 32'hCAFEF00D};
        bus.issue_en   = 1'b1;
        bus.issue_addr = 5'd6;
        bus.read_addr  = {5'd5, 5'd4};
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (bus.ready !== 1'b0 || bus.read_data[0] !== 32'h0 || bus.read_pending !== 2'b00) begin
                bad++; $display("FAIL clear_outputs cycle=%0d actual=%0b/%h/%b expected=0/0/00",
                                k, bus.ready, bus.read_data[0], bus.read_pending);
            end
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            total++;
            if (bus.ready !== (k == 32)) begin
                bad++; $display("FAIL mid_clear_latency cycle=%0d actual=%0b expected=%0b", k, bus.ready, (k == 32));
            end
        end
        idle_inputs();
        for (int a = 3; a <= 9; a++) begin
            bus.read_addr = {5'(a), 5'(a)};
            #1;
            total++;
            if (bus.read_data[0] !== 32'h0 || bus.read_pending !== 2'b00) begin
                bad++; $display("FAIL post_clear addr=%0d actual=%h/%b expected=0/00", a, bus.read_data[0], bus.read_pending);
            end
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.read_addr = '0;
        idle_inputs();
        test_reset();
        test_write_conflict();
        test_reg_zero();
        test_scoreboard();
        test_bypass();
        test_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
